// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  // Memory access size as decoded by the control logic; encoding 2'd3 is illegal.
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Consecutive data grants allowed while a fetch waits (legal range 1..15).
  localparam int MAX_D_STREAK_DEF = 4;
  localparam int STREAK_W         = 4;

  // True when a data access cannot be issued: unaligned half/word or illegal size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return addr_lo[0];
      WORD:    return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch-stage, memory-stage and memory-model signals of the arbiter.
// The master modport is the arbiter's view; slave is the view of everything around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  // Fetch stage
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_ack_o;
  logic [DATA_W-1:0] i_rdata_o;

  // Memory stage
  logic              d_req_i;
  logic              d_we_i;
  logic [1:0]        d_size_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_ack_o;
  logic              d_err_o;
  logic [DATA_W-1:0] d_rdata_o;

  // Pipeline control
  logic              flush_i;
  logic              stall_o;

  // Memory model
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_be_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    input  i_req_i, i_addr_i, d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
           flush_i, mem_ack_i, mem_rdata_i,
    output i_ack_o, i_rdata_o, d_ack_o, d_err_o, d_rdata_o, stall_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );

  modport slave (
    output i_req_i, i_addr_i, d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
           flush_i, mem_ack_i, mem_rdata_i,
    input  i_ack_o, i_rdata_o, d_ack_o, d_err_o, d_rdata_o, stall_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_lane_gen.sv
// Byte-enable and store-lane generator: maps access size and address low bits
// to byte enables, replicates store data across lanes and flags bad accesses.
module mem_lane_gen
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        misaligned
);

  // Decode size into enables and replicated store data.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    be         = 4'b0000;
    wdata_lane = '0;
    misaligned = is_misaligned(size, addr_lo);
    case (size)
      BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      HALF: begin
        be         = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
      end
      WORD: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and the memory stage. Tracks a single
// outstanding transaction, limits data-grant streaks so fetch cannot starve,
// rejects misaligned data accesses and drops fetch responses after a flush.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input logic            clk,
  input logic            rst_n,
  mem_port_arbiter_if.master bus
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state;
  logic [STREAK_W-1:0] streak;
  logic                flush_pend;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [3:0]          mem_be_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                i_ack_q;
  logic                d_ack_q;
  logic                d_err_q;

  logic [3:0]          lane_be;
  logic [31:0]         lane_wdata;
  logic                lane_misaligned;
  logic                d_wins;
  logic                unused_i_addr_lo;

  mem_lane_gen u_lane_gen (
    .size       (bus.d_size_i),
    .addr_lo    (bus.d_addr_i[1:0]),
    .wdata      (bus.d_wdata_i),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .misaligned (lane_misaligned)
  );

  // Data wins IDLE arbitration unless it has used up its streak while fetch waits.
  assign d_wins = bus.d_req_i && !(bus.i_req_i && (streak == STREAK_MAX));

  // Fetch addresses are word aligned; their low bits are never used.
  assign unused_i_addr_lo = ^bus.i_addr_i[1:0];

  // Arbitration FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      streak      <= '0;
      flush_pend  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so a later assignment in this block overrides these defaults.
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
      if (!bus.i_req_i) streak <= '0;

      case (state)
        IDLE: begin
          if (d_wins) begin
            if (bus.i_req_i) streak <= streak + 1'b1;
            if (lane_misaligned) begin
              state   <= RESP;
              d_ack_q <= 1'b1;
              d_err_q <= 1'b1;
            end else begin
              state       <= BUSY_D;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.d_we_i;
              mem_addr_q  <= {bus.d_addr_i[ADDR_W-1:2], 2'b00};
              mem_be_q    <= lane_be;
              mem_wdata_q <= lane_wdata;
            end
          end else if (bus.i_req_i) begin
            streak      <= '0;
            state       <= BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {bus.i_addr_i[ADDR_W-1:2], 2'b00};
            mem_be_q    <= 4'b1111;
            mem_wdata_q <= '0;
          end
        end

        BUSY_I: begin
          if (bus.mem_ack_i) begin
            rdata_q    <= bus.mem_rdata_i;
            mem_req_q  <= 1'b0;
            state      <= RESP;
            // A flush on the completing cycle also discards the response.
            i_ack_q    <= !(flush_pend || bus.flush_i);
            flush_pend <= flush_pend || bus.flush_i;
          end else if (bus.flush_i) begin
            flush_pend <= 1'b1;
          end
        end

        BUSY_D: begin
          if (bus.mem_ack_i) begin
            rdata_q   <= bus.mem_rdata_i;
            mem_req_q <= 1'b0;
            state     <= RESP;
            d_ack_q   <= 1'b1;
          end
        end

        RESP: begin
          flush_pend <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_be_o    = mem_be_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.i_ack_o     = i_ack_q;
  assign bus.i_rdata_o   = rdata_q;
  assign bus.d_ack_o     = d_ack_q;
  assign bus.d_err_o     = d_err_q;
  assign bus.d_rdata_o   = rdata_q;
  assign bus.stall_o     = (bus.i_req_i && !i_ack_q) || (bus.d_req_i && !d_ack_q);

endmodule
